// File: rtl/washer_pkg.sv
// Shared washer definitions: motor FSM states and
// default interlock timing constants.
package washer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    REV,
    BRAKE
  } motor_state_t;

  localparam int DEF_DEAD_TIME = 50;
  localparam int DEF_MIN_ON    = 20;

endpackage

// File: rtl/dwell_counter.sv
// Saturating dwell counter with synchronous clear
// and a >= limit compare output.
module dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             reached
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign reached = (cnt >= limit);

endmodule

// File: rtl/wash_drive_interlock.sv
// Valve/motor drive interlock: lid gating, minimum
// motor on-time, direction dead-time and conflict fault.
module wash_drive_interlock
  import washer_pkg::*;
#(
  parameter int DEAD_TIME = DEF_DEAD_TIME,
  parameter int MIN_ON    = DEF_MIN_ON,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ctrl_fill,
  input  logic ctrl_release,
  input  logic ctrl_forward,
  input  logic ctrl_reverse,
  input  logic lid_closed,
  input  logic fault_clr,
  output logic drv_fill,
  output logic drv_drain,
  output logic drv_fwd,
  output logic drv_rev,
  output logic fault,
  output logic busy
);

  // Counter starts at 0 on entry, so limits are one less than
  // the number of cycles to spend in the state.
  localparam logic [CNT_W-1:0] DT_LIM = CNT_W'(DEAD_TIME - 1);
  localparam logic [CNT_W-1:0] MO_LIM = CNT_W'(MIN_ON - 1);

  motor_state_t state_q;
  motor_state_t state_d;

  logic             fault_d;
  logic             dir_conf;
  logic             vlv_conf;
  logic             cnt_clr;
  logic             reached;
  logic [CNT_W-1:0] limit;

  assign dir_conf = ctrl_forward & ctrl_reverse;
  assign vlv_conf = ctrl_fill & ctrl_release;
  assign limit    = (state_q == BRAKE) ? DT_LIM : MO_LIM;
  assign cnt_clr  = (state_d != state_q);

  dwell_counter #(
    .CNT_W(CNT_W)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .limit  (limit),
    .reached(reached)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ctrl_forward & ~ctrl_reverse &
            lid_closed & ~fault) begin
          state_d = FWD;
        end else if (ctrl_reverse & ~ctrl_forward &
                     lid_closed & ~fault) begin
          state_d = REV;
        end
      end
      FWD: begin
        if (~lid_closed | fault | dir_conf) begin
          state_d = BRAKE;
        end else if (~ctrl_forward & reached) begin
          state_d = BRAKE;
        end
      end
      REV: begin
        if (~lid_closed | fault | dir_conf) begin
          state_d = BRAKE;
        end else if (~ctrl_reverse & reached) begin
          state_d = BRAKE;
        end
      end
      BRAKE: begin
        if (reached) begin
          state_d = IDLE;
        end
      end
      default: state_d = BRAKE;
    endcase
  end

  always_comb begin
    fault_d = fault;
    if (dir_conf | vlv_conf) begin
      fault_d = 1'b1;
    end else if (fault_clr) begin
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BRAKE;
      drv_fwd   <= 1'b0;
      drv_rev   <= 1'b0;
      busy      <= 1'b1;
      drv_fill  <= 1'b0;
      drv_drain <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      drv_fwd   <= (state_d == FWD);
      drv_rev   <= (state_d == REV);
      busy      <= (state_d != IDLE);
      drv_fill  <= ctrl_fill & ~ctrl_release &
                   lid_closed & ~fault;
      drv_drain <= ctrl_release;
      fault     <= fault_d;
    end
  end

endmodule

// File: tb/tb_wash_drive_interlock.sv
// Directed + randomized bench for wash_drive_interlock
// against a countdown-based behavioural model.
module tb_wash_drive_interlock;

  localparam int DT = 4;
  localparam int MO = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic f = 1'b0, r = 1'b0;
  logic fill = 1'b0, rel = 1'b0;
  logic lid = 1'b0, clr = 1'b0;
  logic drv_fill, drv_drain, drv_fwd, drv_rev;
  logic fault, busy;

  int total = 0;
  int passed = 0;

  // Model: direction (-1/0/+1), brake cycles left, driven cycles so far
  int m_dir, m_brk, m_on;
  bit m_fault, m_fill, m_drain;

  wash_drive_interlock #(
    .DEAD_TIME(DT),
    .MIN_ON   (MO),
    .CNT_W    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctrl_fill   (fill),
    .ctrl_release(rel),
    .ctrl_forward(f),
    .ctrl_reverse(r),
    .lid_closed  (lid),
    .fault_clr   (clr),
    .drv_fill    (drv_fill),
    .drv_drain   (drv_drain),
    .drv_fwd     (drv_fwd),
    .drv_rev     (drv_rev),
    .fault       (fault),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  task automatic model_reset();
    m_dir = 0;
    m_brk = DT;
    m_on = 0;
    m_fault = 0;
    m_fill = 0;
    m_drain = 0;
  endtask

  task automatic model_step();
    bit fo;
    bit want;
    fo = m_fault;
    if ((f && r) || (fill && rel)) m_fault = 1;
    else if (clr) m_fault = 0;
    m_fill = fill && !rel && lid && !fo;
    m_drain = rel;
    if (m_brk > 0) begin
      m_brk--;
    end else if (m_dir == 0) begin
      if (f && !r && lid && !fo) begin
        m_dir = 1;
        m_on = 1;
      end else if (r && !f && lid && !fo) begin
        m_dir = -1;
        m_on = 1;
      end
    end else begin
      want = (m_dir > 0) ? f : r;
      if (!lid || fo || (f && r) || (!want && m_on >= MO)) begin
        m_dir = 0;
        m_brk = DT;
      end else begin
        m_on++;
      end
    end
  endtask

  task automatic check_all();
    check("drv_fwd", drv_fwd, m_dir > 0);
    check("drv_rev", drv_rev, m_dir < 0);
    check("busy", busy, (m_dir != 0) || (m_brk > 0));
    check("drv_fill", drv_fill, m_fill);
    check("drv_drain", drv_drain, m_drain);
    check("fault", fault, m_fault);
    check("no_overlap", drv_fwd & drv_rev, 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      cycle();
      n++;
    end
    check(tag, busy, 0);
  endtask

  initial begin
    int n;
    model_reset();
    // Reset held with forward request and lid closed
    f = 1;
    lid = 1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_fwd", drv_fwd, 0);
      check("rst_busy", busy, 1);
      check_all();
    end
    rst_n = 1;
    n = 0;
    while (!drv_fwd && n < 20) begin
      cycle();
      n++;
    end
    check("rst_start_edges", n, 5);

    // Reversal
    repeat (8) cycle();
    f = 0;
    r = 1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!drv_rev && n < 30);
    check("rev_gap_edges", n, 6);

    // Min-on from a one-cycle pulse
    r = 0;
    wait_idle("idle_before_minon");
    f = 1;
    cycle();
    f = 0;
    n = 0;
    while (drv_fwd && n < 20) begin
      n++;
      cycle();
    end
    check("minon_cycles", n, MO);
    n = 0;
    while (busy && n < 20) begin
      n++;
      cycle();
    end
    check("brake_cycles", n, DT);

    // Lid opens during forward with fill requested
    fill = 1;
    f = 1;
    cycle();
    check("lid_fwd_on", drv_fwd, 1);
    check("lid_fill_on", drv_fill, 1);
    lid = 0;
    cycle();
    check("lid_fwd_off", drv_fwd, 0);
    check("lid_fill_off", drv_fill, 0);
    fill = 0;
    rel = 1;
    cycle();
    check("lid_drain", drv_drain, 1);
    f = 0;
    rel = 0;
    wait_idle("idle_after_lid");
    lid = 1;

    // Direction conflict and fault clear
    f = 1;
    cycle();
    r = 1;
    cycle();
    check("dconf_fault", fault, 1);
    check("dconf_fwd_off", drv_fwd, 0);
    clr = 1;
    cycle();
    check("dconf_clr_held", fault, 1);
    f = 0;
    r = 0;
    cycle();
    check("dconf_cleared", fault, 0);
    clr = 0;

    // Valve conflict
    fill = 1;
    rel = 1;
    cycle();
    check("vconf_drain", drv_drain, 1);
    check("vconf_fill", drv_fill, 0);
    check("vconf_fault", fault, 1);
    fill = 0;
    rel = 0;
    clr = 1;
    cycle();
    check("vconf_cleared", fault, 0);
    clr = 0;

    // Randomized traffic with occasional mid-run resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) f = ~f;
      if ($urandom_range(0, 7) == 0) r = ~r;
      if ($urandom_range(0, 5) == 0) fill = ~fill;
      if ($urandom_range(0, 9) == 0) rel = ~rel;
      lid = ($urandom_range(0, 31) != 0);
      clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1;
      end else begin
        cycle();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
